// File: rtl/tri_matrix_inv.sv
// Complex lower-triangular matrix inverse by forward substitution, one element per cycle.
// Rows are fetched by address into a local buffer; each finished column is emitted as a one-cycle pulse.
module tri_matrix_inv #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [SIZE-1:0][2*WIDTH-1:0]     mat_row_i,
  input  logic                             mat_row_valid_i,
  input  logic [AW-1:0]                    mat_row_addr_i,
  output logic [AW-1:0]                    mat_row_addr_o,
  output logic                             mat_row_addr_valid_o,
  output logic [2*SIZE-1:0][WIDTH-1:0]     inv_col_o,
  output logic                             inv_col_valid_o,
  output logic                             in_ready_o,
  input  logic                             flush_i,
  input  logic                             start,
  output logic                             busy_o
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, COMPUTE, EMIT} state_t;

  state_t                                state_q, state_nxt;
  logic [AW-1:0]                         addr_q, k_q, i_q;
  logic [SIZE-1:0]                       captured_q, captured_all;
  logic [SIZE-1:0][SIZE-1:0][2*WIDTH-1:0] rows_q;
  logic [SIZE-1:0][2*WIDTH-1:0]          col_q;
  logic [2*WIDTH-1:0]                    new_elem, elem;
  logic [2*SIZE-1:0][WIDTH-1:0]          col_out;
  logic                                  capture;

  assign capture      = (state_q == FETCH || state_q == WAIT) && mat_row_valid_i;
  assign captured_all = captured_q | (capture ? (SIZE'(1) << mat_row_addr_i) : '0);

  // X[i][k] from the partially built column k; the diagonal step uses numerator 1
  always_comb begin : datapath
    real acc_re, acc_im, lr, li, xr, xi, num_re, num_im, c, d, den, res_re, res_im;
    acc_re = 0.0; acc_im = 0.0; lr = 0.0; li = 0.0; xr = 0.0; xi = 0.0;
    for (int j = 0; j < SIZE; j++) begin
      if (j >= int'(k_q) && j < int'(i_q)) begin
        lr = $bitstoreal(rows_q[i_q][j][WIDTH-1:0]);
        li = $bitstoreal(rows_q[i_q][j][2*WIDTH-1:WIDTH]);
        xr = $bitstoreal(col_q[j][WIDTH-1:0]);
        xi = $bitstoreal(col_q[j][2*WIDTH-1:WIDTH]);
        acc_re = acc_re + (lr * xr - li * xi);
        acc_im = acc_im + (lr * xi + li * xr);
      end
    end
    if (i_q == k_q) begin
      num_re = 1.0;
      num_im = 0.0;
    end else begin
      num_re = -acc_re;
      num_im = -acc_im;
    end
    c      = $bitstoreal(rows_q[i_q][i_q][WIDTH-1:0]);
    d      = $bitstoreal(rows_q[i_q][i_q][2*WIDTH-1:WIDTH]);
    den    = c * c + d * d;
    res_re = (num_re * c + num_im * d) / den;
    res_im = (num_im * c - num_re * d) / den;
    new_elem = {$realtobits(res_im), $realtobits(res_re)};
  end

  // Emitted column: current element merged in, entries above the diagonal forced to +0.0
  always_comb begin
    elem    = '0;
    col_out = '0;
    for (int i = 0; i < SIZE; i++) begin
      elem = (i == int'(i_q)) ? new_elem : col_q[i];
      if (i < int'(k_q)) elem = '0;
      col_out[2*i]   = elem[WIDTH-1:0];
      col_out[2*i+1] = elem[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (int'(addr_q) == SIZE-1) state_nxt = WAIT;
      WAIT:    if (&captured_all) state_nxt = COMPUTE;
      COMPUTE: if (int'(i_q) == SIZE-1) state_nxt = EMIT;
      EMIT:    state_nxt = (int'(k_q) == SIZE-1) ? IDLE : COMPUTE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  assign busy_o               = (state_q != IDLE);
  assign in_ready_o           = ~busy_o;
  assign mat_row_addr_valid_o = (state_q == FETCH);
  assign mat_row_addr_o       = (state_q == FETCH) ? addr_q : '0;
  assign inv_col_valid_o      = (state_q == EMIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      k_q        <= '0;
      i_q        <= '0;
      captured_q <= '0;
      rows_q     <= '0;
      col_q      <= '0;
      inv_col_o  <= '0;
    end else begin
      state_q <= state_nxt;
      if (capture) begin
        rows_q[mat_row_addr_i]     <= mat_row_i;
        captured_q[mat_row_addr_i] <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          addr_q     <= '0;
          captured_q <= '0;
        end
        FETCH: addr_q <= addr_q + AW'(1);
        WAIT: begin
          k_q <= '0;
          i_q <= '0;
        end
        COMPUTE: if (!flush_i) begin
          col_q[i_q] <= new_elem;
          if (int'(i_q) == SIZE-1) inv_col_o <= col_out;
          else                     i_q       <= i_q + AW'(1);
        end
        EMIT: begin
          k_q <= k_q + AW'(1);
          i_q <= k_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_matrix_inv.sv
// Directed bench: identity, diagonal, random complex, flush and reset cases on SIZE=16, plus a SIZE=2 instance.
module tb_tri_matrix_inv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] cpx(input real re, input real im);
    return {$realtobits(im), $realtobits(re)};
  endfunction

  // ---------------- SIZE=16 instance ----------------
  logic [127:0]          lmem [16][16];
  logic [15:0][127:0]    row16;
  logic                  m_vld;
  logic [3:0]            m_addr, req_addr;
  logic                  req_vld, col_vld, in_rdy, busy, flush, start;
  logic [31:0][63:0]     inv_col;

  tri_matrix_inv #(.SIZE(16), .WIDTH(64)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .mat_row_i(row16), .mat_row_valid_i(m_vld), .mat_row_addr_i(m_addr),
    .mat_row_addr_o(req_addr), .mat_row_addr_valid_o(req_vld),
    .inv_col_o(inv_col), .inv_col_valid_o(col_vld),
    .in_ready_o(in_rdy), .flush_i(flush), .start(start), .busy_o(busy)
  );

  always @(posedge clk) begin
    m_vld  <= req_vld;
    m_addr <= req_addr;
  end
  always_comb for (int j = 0; j < 16; j++) row16[j] = lmem[m_addr][j];

  logic [31:0][63:0] got [16];
  int ptime [16];
  int npulse = 0;
  int base   = 0;
  always @(posedge clk) begin
    #1;
    if (col_vld) begin
      if (npulse - base >= 0 && npulse - base < 16) begin
        got[npulse-base]   = inv_col;
        ptime[npulse-base] = cyc;
      end
      npulse = npulse + 1;
    end
  end

  // ---------------- SIZE=2 instance ----------------
  logic [127:0]       lmem2 [2][2];
  logic [1:0][127:0]  row2;
  logic               m2_vld;
  logic [0:0]         m2_addr, req2_addr;
  logic               req2_vld, col2_vld, in2_rdy, busy2, flush2, start2;
  logic [3:0][63:0]   inv_col2;

  tri_matrix_inv #(.SIZE(2), .WIDTH(64)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .mat_row_i(row2), .mat_row_valid_i(m2_vld), .mat_row_addr_i(m2_addr),
    .mat_row_addr_o(req2_addr), .mat_row_addr_valid_o(req2_vld),
    .inv_col_o(inv_col2), .inv_col_valid_o(col2_vld),
    .in_ready_o(in2_rdy), .flush_i(flush2), .start(start2), .busy_o(busy2)
  );

  always @(posedge clk) begin
    m2_vld  <= req2_vld;
    m2_addr <= req2_addr;
  end
  always_comb for (int j = 0; j < 2; j++) row2[j] = lmem2[m2_addr][j];

  logic [3:0][63:0] got2 [2];
  int npulse2 = 0;
  always @(posedge clk) begin
    #1;
    if (col2_vld) begin
      if (npulse2 < 2) got2[npulse2] = inv_col2;
      npulse2 = npulse2 + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic load_diag(input real v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        lmem[i][j] = (i == j) ? cpx(v, 0.0) : (j > i ? cpx(77.0, -5.0) : cpx(0.0, 0.0));
  endtask

  task automatic load_random();
    real a, b;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        a = real'(int'($urandom_range(2000)) - 1000) / 2000.0;
        b = real'(int'($urandom_range(2000)) - 1000) / 2000.0;
        if (j == i)     lmem[i][j] = cpx(1.5 + (a + 0.5), b);
        else if (j < i) lmem[i][j] = cpx(a, b);
        else            lmem[i][j] = cpx(1.0e6, -1.0e6);
      end
  endtask

  task automatic start_run();
    base = npulse;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int c = 0;
    while (npulse - base < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(npulse - base), 64'(n));
  endtask

  task automatic check_diag(input real v, input string tag);
    int bad;
    real gr, gi;
    for (int k = 0; k < 16; k++) begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        gr = $bitstoreal(got[k][2*i]);
        gi = $bitstoreal(got[k][2*i+1]);
        if (gr != ((i == k) ? v : 0.0) || gi != 0.0) bad++;
        if (i < k && (got[k][2*i] != 64'd0 || got[k][2*i+1] != 64'd0)) bad++;
      end
      check($sformatf("%s_col%0d_bad", tag, k), 64'(bad), 64'd0);
    end
  endtask

  task automatic check_prod();
    real sr, si, lr, li, xr, xi, err;
    for (int k = 0; k < 16; k++) begin
      err = 0.0;
      for (int i = 0; i < 16; i++) begin
        sr = 0.0; si = 0.0;
        for (int j = 0; j <= i; j++) begin
          lr = $bitstoreal(lmem[i][j][63:0]);
          li = $bitstoreal(lmem[i][j][127:64]);
          xr = $bitstoreal(got[k][2*j]);
          xi = $bitstoreal(got[k][2*j+1]);
          sr = sr + lr * xr - li * xi;
          si = si + lr * xi + li * xr;
        end
        if (i == k) sr = sr - 1.0;
        if (sr < 0.0) sr = -sr;
        if (si < 0.0) si = -si;
        if (sr > err) err = sr;
        if (si > err) err = si;
      end
      check($sformatf("lx_col%0d_within_tol", k), {63'd0, err <= 1.0e-9}, 64'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; start2 = 1'b0; flush2 = 1'b0;
    load_diag(1.0);
    lmem2[0][0] = cpx(1.0, 0.0); lmem2[0][1] = cpx(7.0, 7.0);
    lmem2[1][0] = cpx(2.0, 0.0); lmem2[1][1] = cpx(1.0, 0.0);
    repeat (3) @(negedge clk);

    check("rst_in_ready", 64'(in_rdy), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr_vld", 64'(req_vld), 64'd0);
    check("rst_addr", 64'(req_addr), 64'd0);
    check("rst_col_vld", 64'(col_vld), 64'd0);
    check("rst_col_zero", {63'd0, |inv_col}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // flush and start together in IDLE: stays idle
    start = 1'b1; flush = 1'b1;
    @(negedge clk) begin start = 1'b0; flush = 1'b0; end
    check("flush_beats_start", 64'(busy), 64'd0);

    // identity
    load_diag(1.0);
    start_run();
    check("fetch_busy", 64'(busy), 64'd1);
    wait_pulses(16, 1000, "id_pulses");
    check_diag(1.0, "id");
    repeat (3) @(negedge clk);
    check("id_done_ready", 64'(in_rdy), 64'd1);

    // diag(2): values and pulse spacing 17-k before column k
    load_diag(2.0);
    start_run();
    wait_pulses(16, 1000, "d2_pulses");
    check_diag(0.5, "d2");
    for (int k = 1; k < 16; k++)
      check($sformatf("d2_spacing%0d", k), 64'(ptime[k] - ptime[k-1]), 64'(17 - k));

    // random complex, L*X must be I
    load_random();
    start_run();
    wait_pulses(16, 1000, "rnd_pulses");
    check_prod();

    // flush inside COMPUTE of column 5
    start_run();
    wait_pulses(5, 1000, "fl_pre_pulses");
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_ready", 64'(in_rdy), 64'd1);
    repeat (60) @(negedge clk);
    check("fl_no_more_pulses", 64'(npulse - base), 64'd5);
    load_diag(1.0);
    start_run();
    wait_pulses(16, 1000, "fl_restart_pulses");
    check_diag(1.0, "flr");

    // asynchronous reset in the middle of FETCH
    load_diag(2.0);
    start_run();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_addr_vld", 64'(req_vld), 64'd0);
    check("arst_ready", 64'(in_rdy), 64'd1);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_no_pulse", 64'(npulse - base), 64'd0);
    start_run();
    wait_pulses(16, 1000, "arst_run_pulses");
    check_diag(0.5, "ar");

    // SIZE=2: [[1,0],[2,1]] -> col0=(1,-2), col1=(0,1)
    npulse2 = 0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int c = 0; c < 100 && npulse2 < 2; c++) @(negedge clk);
    check("s2_pulses", 64'(npulse2), 64'd2);
    check("s2_x00", got2[0][0], $realtobits(1.0));
    check("s2_x00_im_zero", {63'd0, $bitstoreal(got2[0][1]) == 0.0}, 64'd1);
    check("s2_x10", got2[0][2], $realtobits(-2.0));
    check("s2_x10_im_zero", {63'd0, $bitstoreal(got2[0][3]) == 0.0}, 64'd1);
    check("s2_x01_re", got2[1][0], 64'd0);
    check("s2_x01_im", got2[1][1], 64'd0);
    check("s2_x11", got2[1][2], $realtobits(1.0));

    // L00 = j -> X00 = -j, X10 = -(2*(-j))/1 = 2j
    lmem2[0][0] = cpx(0.0, 1.0);
    npulse2 = 0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int c = 0; c < 100 && npulse2 < 2; c++) @(negedge clk);
    check("s2j_pulses", 64'(npulse2), 64'd2);
    check("s2j_x00_re_zero", {63'd0, $bitstoreal(got2[0][0]) == 0.0}, 64'd1);
    check("s2j_x00_im", got2[0][1], $realtobits(-1.0));
    check("s2j_x10_im", got2[0][3], $realtobits(2.0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
